// File: rtl/sevenseg_mux_n.sv
// sevenseg_mux_n: time-multiplexed driver for NDIGITS common-anode seven-segment
// digits on a shared segment bus. Each digit owns a slot of 2**DIV_BITS clocks that
// opens with DEAD_CYCLES of blanking, so no digit ghosts into its neighbour. Display
// data is double-buffered and swapped only at the frame boundary, so a frame never tears.
`timescale 1ns/1ps
module sevenseg_mux_n #(
  parameter int NDIGITS     = 4,
  parameter int DIV_BITS    = 16,
  parameter int DEAD_CYCLES = 64
) (
  input  logic                   int_osc,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   digits,
  input  logic [NDIGITS-1:0]     digit_en,
  input  logic [NDIGITS-1:0]     dp,
  input  logic                   load,
  output logic [6:0]             seg,
  output logic                   dp_out,
  output logic [NDIGITS-1:0]     anode,
  output logic                   frame_done
);

  localparam int                  IDX_W     = $clog2(NDIGITS);
  localparam logic [DIV_BITS-1:0] CNT_MAX   = '1;
  localparam logic [DIV_BITS-1:0] CNT_PRE   = CNT_MAX - DIV_BITS'(1);
  localparam logic [DIV_BITS-1:0] DEAD_LAST = DIV_BITS'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NDIGITS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  logic [DIV_BITS-1:0]          cnt;
  logic [IDX_W-1:0]             idx;
  state_t                       state, next_state;
  logic                         slot_end, frame_end;

  // Digit k of a buffer is entry [k], matching digits[4k+3:4k] of the input bus.
  logic [NDIGITS-1:0][3:0]      pend_dig, act_dig;
  logic [NDIGITS-1:0]           pend_en, act_en;
  logic [NDIGITS-1:0]           pend_dp, act_dp;

  logic [6:0]                   seg_d;
  logic                         dp_d;
  logic [NDIGITS-1:0]           anode_d;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Hex nibble to active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Slot timebase: cnt wraps every slot, idx advances on each wrap and wraps per frame.
  // NOTE: all clocked state uses non-blocking assignment so every register samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + DIV_BITS'(1);
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // Double buffer: load fills pending; the frame boundary moves pending to active,
  // taking the live inputs instead when a load lands exactly on the boundary edge.
  // The buffers are plain registers and are cleared so the display starts dark.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      pend_dig <= '0;
      pend_en  <= '0;
      pend_dp  <= '0;
      act_dig  <= '0;
      act_en   <= '0;
      act_dp   <= '0;
    end else begin
      if (load) begin
        pend_dig <= digits;
        pend_en  <= digit_en;
        pend_dp  <= dp;
      end
      if (frame_end) begin
        act_dig <= load ? digits   : pend_dig;
        act_en  <= load ? digit_en : pend_en;
        act_dp  <= load ? dp       : pend_dp;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) state <= BLANK;
    else       state <= next_state;
  end

  // FSM next state: blank for the dead time, then drive until the slot wraps.
  always_comb begin
    next_state = state;
    case (state)
      BLANK:   if (cnt == DEAD_LAST) next_state = DRIVE;
      DRIVE:   if (slot_end)         next_state = BLANK;
      default: next_state = BLANK;
    endcase
  end

  // FSM outputs, computed for the upcoming state so the registered seg and anode
  // change together on one edge. A disabled digit keeps its segments dark too.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    anode_d = '1;
    if (next_state == DRIVE && act_en[idx]) begin
      seg_d        = hex7(act_dig[idx]);
      dp_d         = ~act_dp[idx];
      anode_d[idx] = 1'b0;
    end
  end

  // Output registers; frame_done is registered one clock early so it is high
  // during the last clock of the final digit's slot.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      seg        <= 7'h7F;
      dp_out     <= 1'b1;
      anode      <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      dp_out     <= dp_d;
      anode      <= anode_d;
      frame_done <= (cnt == CNT_PRE) && (idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_sevenseg_mux_n.sv
// Bench for sevenseg_mux_n with 2 digits, 8-clock slots, 2 dead clocks (16-clock frame).
// Expected outputs come from a frame-level model: the data shown in frame f is the
// last load issued before frame f began; position within the frame gives slot and phase.
`timescale 1ns/1ps
module tb_sevenseg_mux_n;

  localparam int ND = 2;

  logic          int_osc = 1'b0;
  logic          reset;
  logic [7:0]    digits;
  logic [1:0]    digit_en;
  logic [1:0]    dp;
  logic          load;
  logic [6:0]    seg;
  logic          dp_out;
  logic [1:0]    anode;
  logic          frame_done;

  sevenseg_mux_n #(.NDIGITS(ND), .DIV_BITS(3), .DEAD_CYCLES(2)) dut (
    .int_osc    (int_osc),
    .reset      (reset),
    .digits     (digits),
    .digit_en   (digit_en),
    .dp         (dp),
    .load       (load),
    .seg        (seg),
    .dp_out     (dp_out),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 int_osc = ~int_osc;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic [1:0] en;
    logic [1:0] p;
  } ld_t;

  ld_t        loads[$];
  int         k;
  int         checks = 0;
  int         errors = 0;
  logic       prev_valid;
  logic [6:0] prev_seg;
  logic [1:0] prev_anode;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s k=%0d got %h exp %h", tag, k, got, exp);
    end
  endtask

  // Compare all outputs for the current clock k against the frame model.
  task automatic check_now();
    int         f, slot, pos;
    logic [7:0] d;
    logic [1:0] en, p;
    logic       lit;
    logic [6:0] e_seg;
    logic [1:0] e_anode;
    logic       e_dp;
    f    = k / 16;
    slot = (k / 8) % 2;
    pos  = k % 8;
    d = 8'h00; en = 2'b00; p = 2'b00;
    foreach (loads[i]) if (loads[i].k < 16 * f) begin
      d = loads[i].d; en = loads[i].en; p = loads[i].p;
    end
    lit     = (pos >= 2) && en[slot];
    e_anode = lit ? ~(2'b01 << slot) : 2'b11;
    e_seg   = lit ? dec[slot ? d[7:4] : d[3:0]] : 7'h7F;
    e_dp    = lit ? ~p[slot] : 1'b1;
    chk("anode", {6'd0, anode}, {6'd0, e_anode});
    chk("seg", {1'b0, seg}, {1'b0, e_seg});
    chk("dp_out", {7'd0, dp_out}, {7'd0, e_dp});
    chk("frame_done", {7'd0, frame_done}, {7'd0, (k % 16) == 15});
    chk("one_anode", {7'd0, $countones(~anode) <= 1}, 8'd1);
    if (prev_valid && prev_anode != 2'b11 && anode != 2'b11) begin
      chk("stable_anode", {6'd0, anode}, {6'd0, prev_anode});
      chk("stable_seg", {1'b0, seg}, {1'b0, prev_seg});
    end
    prev_valid = 1'b1;
    prev_seg   = seg;
    prev_anode = anode;
  endtask

  // One clock: check the present outputs, drive inputs sampled at the next edge.
  task automatic step(input logic ld, input logic [7:0] d, input logic [1:0] en,
                      input logic [1:0] p);
    ld_t e;
    check_now();
    load = ld; digits = d; digit_en = en; dp = p;
    if (ld) begin
      e.k = k; e.d = d; e.en = en; e.p = p;
      loads.push_back(e);
    end
    @(posedge int_osc);
    @(negedge int_osc);
    k++;
    load = 1'b0;
  endtask

  task automatic run_until(input int target);
    while (k < target) step(1'b0, 8'h00, 2'b00, 2'b00);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge int_osc);
    @(negedge int_osc);
    reset = 1'b0;
    k = 0;
    loads.delete();
    prev_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; digits = '0; digit_en = '0; dp = '0;
    k = 0; prev_valid = 1'b0;
    #1;
    chk("rst_anode", {6'd0, anode}, 8'h03);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'd0, dp_out}, 8'h01);
    chk("rst_fd", {7'd0, frame_done}, 8'h00);
    apply_reset();

    // First frame with nothing loaded stays dark; frame_done on clock 15.
    run_until(15);
    chk("fd_clk15", {7'd0, frame_done}, 8'h01);
    run_until(16);

    // Load 81 in frame 1; frame 2 shows 1 then 8 after the dead time.
    step(1'b1, 8'h81, 2'b11, 2'b00);
    run_until(33);
    chk("t2_dead", {6'd0, anode}, 8'h03);
    run_until(34);
    chk("t2_d0_an", {6'd0, anode}, 8'h02);
    chk("t2_d0_seg", {1'b0, seg}, 8'h79);
    run_until(42);
    chk("t2_d1_an", {6'd0, anode}, 8'h01);
    chk("t2_d1_seg", {1'b0, seg}, 8'h00);

    // Mid-frame load does not disturb the current frame.
    step(1'b1, 8'hF0, 2'b11, 2'b00);
    run_until(45);
    chk("t3_hold", {1'b0, seg}, 8'h00);
    run_until(50);
    chk("t3_d0", {1'b0, seg}, 8'h40);
    run_until(58);
    chk("t3_d1", {1'b0, seg}, 8'h0E);

    // Load on the exact boundary edge bypasses straight to the next frame.
    run_until(63);
    step(1'b1, 8'hA5, 2'b11, 2'b00);
    run_until(66);
    chk("t4_d0", {1'b0, seg}, 8'h12);
    run_until(74);
    chk("t4_d1", {1'b0, seg}, 8'h08);

    // Digit 1 disabled, digit 0 with decimal point.
    step(1'b1, 8'hA5, 2'b01, 2'b01);
    run_until(82);
    chk("t5_an0", {6'd0, anode}, 8'h02);
    chk("t5_dp0", {7'd0, dp_out}, 8'h00);
    run_until(90);
    chk("t5_an1", {6'd0, anode}, 8'h03);

    // Reset in slot 1 clock 5 blanks immediately and discards pending data.
    run_until(96);
    step(1'b1, 8'h81, 2'b11, 2'b00);
    step(1'b1, 8'h3C, 2'b11, 2'b11);
    run_until(125);
    chk("t6_lit", {6'd0, anode}, 8'h01);
    reset = 1'b1;
    #1;
    chk("t6_an", {6'd0, anode}, 8'h03);
    chk("t6_seg", {1'b0, seg}, 8'h7F);
    chk("t6_dp", {7'd0, dp_out}, 8'h01);
    apply_reset();
    run_until(20);
    chk("t6_dark", {6'd0, anode}, 8'h03);
    run_until(32);

    // Randomized loads against the frame model.
    repeat (128) begin
      step(($urandom % 5) == 0, 8'($urandom), 2'($urandom), 2'($urandom));
    end
    run_until(k + 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
